// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART blocks: FSM state encoding, mid-bit
// tick index and the oversample divider calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_t;

    localparam logic [3:0] MID_TICK = 4'd7;

    function automatic int uart_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-cycle tick every DIV clocks while enabled;
// clr restarts the count so the first tick lands DIV clocks later.
module uart_baud_tick #(
    parameter int DIV = 54
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver, 16x oversampling, bytes out on a valid/ready handshake.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects odd parity).
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DIV        = uart_div(CLK_FREQ, BAUD, OVERSAMPLE)
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        frame_err,
    output logic        overrun,
    output logic        parity_err,
    output logic        busy,
    output uart_state_t fsm_state
);

    logic        rx_meta, rxs;
    uart_state_t state, state_nxt;
    logic [3:0]  tick_cnt, tick_cnt_nxt;
    logic [2:0]  bit_idx, bit_idx_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic        deliver, deliver_nxt;
    logic        frame_err_nxt;
    logic        tick, tick_en, tick_clr;
`ifdef UART_RX_PARITY_EN
    logic        par_bad, par_bad_nxt;
    logic        parity_err_nxt;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    assign tick_en = (state != IDLE);

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_en),
        .clr  (tick_clr),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            deliver   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            tick_cnt  <= tick_cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shreg     <= shreg_nxt;
            deliver   <= deliver_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    // START samples at tick 7 (mid start bit); every later bit is sampled on
    // the 15->0 wrap, which is exactly one bit-time after the previous sample.
    always_comb begin
        state_nxt     = state;
        tick_cnt_nxt  = tick_cnt;
        bit_idx_nxt   = bit_idx;
        shreg_nxt     = shreg;
        deliver_nxt   = 1'b0;
        frame_err_nxt = 1'b0;
        tick_clr      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_nxt    = par_bad;
        parity_err_nxt = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_nxt    = START;
                    tick_cnt_nxt = '0;
                    tick_clr     = 1'b1;
`ifdef UART_RX_PARITY_EN
                    par_bad_nxt  = 1'b0;
`endif
                end
            end
            START: begin
                if (tick) begin
                    if (tick_cnt == MID_TICK) begin
                        tick_cnt_nxt = '0;
                        if (rxs) begin
                            state_nxt = IDLE;
                        end else begin
                            state_nxt   = DATA;
                            bit_idx_nxt = '0;
                        end
                    end else begin
                        tick_cnt_nxt = tick_cnt + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    tick_cnt_nxt = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        shreg_nxt[bit_idx] = rxs;
                        bit_idx_nxt        = bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_nxt = PARITY;
`else
                            state_nxt = STOP;
`endif
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    tick_cnt_nxt = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        state_nxt = STOP;
                        if (rxs != ((^shreg) ^ PARITY_ODD)) begin
                            parity_err_nxt = 1'b1;
                            par_bad_nxt    = 1'b1;
                        end
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    tick_cnt_nxt = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        if (rxs) begin
`ifdef UART_RX_PARITY_EN
                            deliver_nxt = !par_bad;
`else
                            deliver_nxt = 1'b1;
`endif
                            state_nxt = IDLE;
                        end else begin
                            frame_err_nxt = 1'b1;
                            state_nxt     = BREAK;
                        end
                    end
                end
            end
            BREAK: begin
                if (rxs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_bad    <= par_bad_nxt;
            parity_err <= parity_err_nxt;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    // Handshake: a byte transfers on any cycle with rx_valid && rx_ready; rx_data
    // holds while rx_valid && !rx_ready, and a byte arriving then is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (deliver) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx: serial frames driven bit by bit, outcomes predicted
// from frame contents and the consumer policy, compared through one scoreboard.
module tb_uart_byte_rx;
  import uart_pkg::*;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 10000;
  localparam int BIT_CLKS = 160;
`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_ODD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx = 1'b1;
  logic        rx_ready = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        overrun;
  logic        parity_err;
  logic        busy;
  uart_state_t fsm_state;

  uart_byte_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err),
    .busy       (busy),
    .fsm_state  (fsm_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int exp_fe = 0, exp_ov = 0, exp_pe = 0;
  int got_fe = 0, got_ov = 0, got_pe = 0;
  int unstable = 0;
  int rise_cyc = 0;
  int n_checks = 0, n_errors = 0;

  // reference model: one holding register plus the consumer policy
  bit         consumer_ready = 1'b1;
  bit         m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;

  logic       p_hold = 1'b0, p_valid = 1'b0;
  logic [7:0] p_data = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) got_fe++;
      if (overrun) got_ov++;
      if (parity_err) got_pe++;
      if (p_hold && rx_data != p_data) unstable++;
      if (rx_valid && !p_valid) rise_cyc = cyc;
    end
    p_hold  = rst && rx_valid && !rx_ready;
    p_data  = rx_data;
    p_valid = rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    idle(BIT_CLKS);
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop_bit, input logic par_bad);
    if (!stop_bit) exp_fe++;
    if (par_bad) exp_pe++;
    if (stop_bit && !par_bad) begin
      if (consumer_ready) exp_q.push_back(b);
      else if (!m_valid) begin
        m_valid = 1'b1;
        m_data  = b;
      end else exp_ov++;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bad);
    model_frame(b, stop_bit, par_bad);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ PARITY_ODD ^ par_bad);
`endif
    drive_bit(stop_bit);
    rx = 1'b1;
  endtask

  task automatic compare_sb(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
    check({tag, "_frame_err"}, got_fe, exp_fe);
    check({tag, "_overrun"}, got_ov, exp_ov);
    check({tag, "_parity_err"}, got_pe, exp_pe);
    check({tag, "_stable"}, unstable, 0);
    got_fe = 0; got_ov = 0; got_pe = 0; unstable = 0;
    exp_fe = 0; exp_ov = 0; exp_pe = 0;
  endtask

  initial begin
    int start_cyc, lat, busy_low, kind;
    logic [7:0] b;

    // reset with rx toggling
    rst = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      rx = 1'($urandom_range(0, 1));
      idle(1);
    end
    check("rst_data", rx_data, 8'h00);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_parity_err", parity_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", fsm_state, IDLE);
    rx = 1'b1;
    rst = 1'b1;
    idle(10);
    check("post_rst_valid", rx_valid, 1'b0);
    check("post_rst_busy", busy, 1'b0);

    // single byte, consumer always ready, latency measured from the start edge
    rise_cyc = 0;
    start_cyc = cyc;
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(20);
    lat = rise_cyc - start_cyc;
    check("latency_1523", (lat >= 1512 && lat <= 1535), 1'b1);
    compare_sb("single");

    // two back-to-back bytes into a stalled consumer
    consumer_ready = 1'b0;
    rx_ready = 1'b0;
    send_frame(8'h31, 1'b1, 1'b0);
    send_frame(8'h38, 1'b1, 1'b0);
    idle(5);
    check("ovr_valid", rx_valid, m_valid);
    check("ovr_data", rx_data, m_data);
    rx_ready = 1'b1;
    exp_q.push_back(m_data);
    m_valid = 1'b0;
    idle(1);
    rx_ready = 1'b0;
    #1;
    check("ovr_cleared", rx_valid, m_valid);
    compare_sb("overrun");
    consumer_ready = 1'b1;
    rx_ready = 1'b1;

    // stop bit low followed by a long break
    send_frame(8'h55, 1'b0, 1'b0);
    rx = 1'b0;
    busy_low = 0;
    for (int i = 0; i < 3 * BIT_CLKS - BIT_CLKS; i++) begin
      idle(1);
      if (!busy) busy_low++;
    end
    check("break_busy_low_cycles", busy_low, 0);
    check("break_valid", rx_valid, 1'b0);
    rx = 1'b1;
    idle(6);
    check("break_exit_busy", busy, 1'b0);
    compare_sb("framing");

    // start glitch shorter than half a bit
    rx = 1'b0;
    idle(40);
    rx = 1'b1;
    idle(200);
    check("glitch_busy", busy, 1'b0);
    check("glitch_valid", rx_valid, 1'b0);
    compare_sb("glitch");

    // reset in the middle of a frame
    rx = 1'b0;
    idle(4 * BIT_CLKS);
    rst = 1'b0;
    idle(3);
    check("midrst_busy", busy, 1'b0);
    check("midrst_valid", rx_valid, 1'b0);
    rx = 1'b1;
    rst = 1'b1;
    idle(2 * BIT_CLKS);
    check("midrst_after_busy", busy, 1'b0);
    compare_sb("midreset");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    idle(20);
    check("par_bad_valid", rx_valid, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0);
    idle(20);
    compare_sb("parity");
`endif

    // randomized mix of good frames, framing errors and glitches
    for (int n = 0; n < 14; n++) begin
      kind = $urandom_range(0, 9);
      b = 8'($urandom_range(0, 255));
      if (kind < 7) begin
        send_frame(b, 1'b1, 1'b0);
        idle($urandom_range(0, 60));
      end else if (kind < 9) begin
        send_frame(b, 1'b0, 1'b0);
        rx = 1'b0;
        idle($urandom_range(0, 300));
        rx = 1'b1;
        idle($urandom_range(5, 60));
      end else begin
        rx = 1'b0;
        idle($urandom_range(5, 60));
        rx = 1'b1;
        idle(120);
      end
    end
    idle(20);
    compare_sb("random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
- Receive end of the clock's serial link: 8N1 UART receiver with 16x oversampling.
- Turns the host's serial stream into bytes on a valid/ready handshake, for the time/date command decoder inside digital_clock.
- Flags framing errors and overruns. One instance per serial input; runs on the system clock.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- OVERSAMPLE, 16, samples per bit; fixed at 16 (mid-bit = tick 7).
- DIV, CLK_FREQ/(BAUD*OVERSAMPLE) (integer floor, 54 at defaults), clocks per oversample tick; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- rx  in  1  serial line, idle high, asynchronous to clk.
- rx_data  out  8  received byte, LSB first on the wire.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: byte completed while the previous byte was unconsumed.
- parity_err  out  1  one-cycle pulse: parity mismatch (see Optional Feature).
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values (rst=0, async): rx_data=0, rx_valid=0, all pulses 0, busy=0, FSM=IDLE, synchronizer flops=1, counters=0.
- Input: 2-flop synchronizer on rx; all logic uses the synchronized value rxs.
- Tick generator: counter 0..DIV-1, one-cycle tick at DIV-1. Free-running only while not in IDLE; cleared on entry to START.
- tick_cnt: 4 bits, counts ticks within a bit and wraps 15->0. bit_idx: 3 bits.
- FSM states and transitions:
  - IDLE: rxs==0 -> START, with tick_cnt=0.
  - START: at tick_cnt==7, if rxs==1 (glitch/false start) -> IDLE with no flags; else tick_cnt=0 -> DATA with bit_idx=0.
  - DATA: at each tick_cnt==15 wrap (mid-bit), shift rxs into shreg[bit_idx]. bit_idx==7 -> STOP (or PARITY when enabled).
  - STOP: at mid-bit, if rxs==1 -> deliver the byte, then IDLE. If rxs==0 -> frame_err pulse, byte discarded, -> BREAK.
  - BREAK: wait for rxs==1, then IDLE. No new start is detected during a break.
- Delivery, in the cycle after the stop sample:
  - If rx_valid==0, or rx_valid && rx_ready in that same cycle: load rx_data, rx_valid=1, no overrun.
  - Else: overrun pulse, new byte dropped, old rx_data/rx_valid retained.
- Handshake: rx_valid stays high until a cycle with rx_ready==1. rx_valid clears on that cycle unless a delivery coincides. rx_data is stable while rx_valid && !rx_ready.
- Latency: rx_valid rises 9.5 bit-times + 3 clocks after the falling start edge on rx (nominal, +-1 tick).
- Back-to-back frames: a start edge is detected in the first IDLE cycle after STOP, which leaves a half-bit margin.
- Reset mid-frame: immediate abort to IDLE with reset values; a partial byte is never delivered.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds parameter PARITY_ODD (default 0 = even) and a PARITY state between DATA and STOP.
  - The parity bit is sampled at mid-bit. On mismatch: parity_err pulse, byte discarded, STOP still checked (frame_err may also pulse).
- Undefined: 8N1 only, parity_err tied 0, no PARITY state.

Decomposition:
- Package uart_pkg holds:
  - FSM state enum: IDLE, START, DATA, PARITY, STOP, BREAK.
  - localparam MID_TICK=7.
  - Function computing DIV from CLK_FREQ/BAUD.
- One sub-module: uart_baud_tick (divider, enable/clear inputs, tick output). Reused later by the transmitter.

Test Plan:
All scenarios use CLK_FREQ=1600000, BAUD=10000, so DIV=10 and 1 bit = 160 clks.
- Reset: hold rst=0 for 5 clks with rx toggling -> all outputs 0, busy=0; release -> idle, rx_valid=0.
- Single byte 0xA5, rx_ready held 1 -> rx_valid pulses 1 cycle with rx_data=0xA5, ~1523 clks after the start edge; no flags.
- Two back-to-back bytes 0x31, 0x38 with rx_ready=0 -> rx_data=0x31 held, overrun pulses once at the second delivery. Then rx_ready=1 for 1 clk -> rx_valid=0.
- Frame 0x55 with stop bit forced 0, then rx held low for 3 bit-times -> frame_err pulses once, rx_valid stays 0, busy stays high until rx returns high.
- Start glitch: rx low for 40 clks (< half bit) -> FSM returns to IDLE, no rx_valid, no flags.
- With UART_RX_PARITY_EN, PARITY_ODD=0: 0x07 sent with parity bit 0 (wrong) -> parity_err pulse, no rx_valid. Same byte with parity bit 1 -> rx_data=0x07 delivered.
